// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// requester and a load/store requester.
//
// Ports
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   if_req, if_addr           fetch request and byte address
//   if_rdata, if_valid        fetched word and one-cycle completion pulse
//   dm_req, dm_we, dm_size    data request, 1=store, size 00=B 01=H 10=W 11=illegal
//   dm_addr, dm_wdata         data byte address and LSB-aligned store data
//   dm_rdata, dm_valid, dm_err  load word shifted down to the LSB, completion
//                             pulse, misalign/illegal-size flag
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be   memory request (word address)
//   mem_ack, mem_rdata        memory handshake and read data
//
// One transaction is in flight at a time: IDLE -> IF_BUSY/DM_BUSY -> DONE -> IDLE.
// Misaligned or illegal data requests bypass memory: IDLE -> DONE with dm_err.
// Every output is a register; the combinational process only computes next values.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [1:0]  dm_size,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_valid,
   output logic        dm_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Part of the data request still needed when the memory answers.
   typedef struct packed {
      logic       we;
      logic [1:0] off;
   } dm_ctx_t;

   state_t      state, state_n;
   logic        last_grant, last_grant_n;   // 1 = data was granted last
   dm_ctx_t     ctx, ctx_n;

   logic [31:0] if_rdata_n;
   logic        if_valid_n;
   logic [31:0] dm_rdata_n;
   logic        dm_valid_n;
   logic        dm_err_n;
   logic        mem_req_n;
   logic        mem_we_n;
   logic [31:0] mem_addr_n;
   logic [31:0] mem_wdata_n;
   logic [3:0]  mem_be_n;

   // Fetches are always whole words; the low address bits carry no meaning.
   logic unused_if_lsb;
   assign unused_if_lsb = ^if_addr[1:0];

   // Decode of the live data request, used only at the grant.
   logic [1:0]  dm_off;
   logic        dm_bad;
   logic [3:0]  dm_be_dec;
   logic [31:0] dm_wdata_rep;

   assign dm_off = dm_addr[1:0];

   always_comb begin
      dm_bad       = 1'b0;
      dm_be_dec    = 4'b1111;
      dm_wdata_rep = dm_wdata;
      case (dm_size)
         2'b00: begin
            dm_be_dec    = 4'b0001 << dm_off;
            dm_wdata_rep = {4{dm_wdata[7:0]}};
         end
         2'b01: begin
            dm_bad       = dm_off[0];
            dm_be_dec    = 4'b0011 << dm_off;
            dm_wdata_rep = {2{dm_wdata[15:0]}};
         end
         2'b10: begin
            dm_bad       = (dm_off != 2'b00);
         end
         default: begin
            dm_bad       = 1'b1;
         end
      endcase
   end

   // Arbitration: a lone requester wins; on a tie the one not served last wins.
   logic grant_dm, grant_if;
   assign grant_dm = dm_req && (!if_req || !last_grant);
   assign grant_if = if_req && !grant_dm;

   always_comb begin
      state_n      = state;
      last_grant_n = last_grant;
      ctx_n        = ctx;
      if_rdata_n   = if_rdata;
      if_valid_n   = 1'b0;
      dm_rdata_n   = dm_rdata;
      dm_valid_n   = 1'b0;
      dm_err_n     = 1'b0;
      mem_req_n    = mem_req;
      mem_we_n     = mem_we;
      mem_addr_n   = mem_addr;
      mem_wdata_n  = mem_wdata;
      mem_be_n     = mem_be;

      case (state)
         IDLE: begin
            if (grant_dm) begin
               last_grant_n = 1'b1;
               ctx_n.we     = dm_we;
               ctx_n.off    = dm_off;
               if (dm_bad) begin
                  // Never reaches memory; report the error straight away.
                  state_n    = DONE;
                  dm_valid_n = 1'b1;
                  dm_err_n   = 1'b1;
                  dm_rdata_n = 32'h0;
               end else begin
                  state_n     = DM_BUSY;
                  mem_req_n   = 1'b1;
                  mem_we_n    = dm_we;
                  mem_addr_n  = {dm_addr[31:2], 2'b00};
                  mem_be_n    = dm_be_dec;
                  mem_wdata_n = dm_we ? dm_wdata_rep : 32'h0;
               end
            end else if (grant_if) begin
               last_grant_n = 1'b0;
               state_n      = IF_BUSY;
               mem_req_n    = 1'b1;
               mem_we_n     = 1'b0;
               mem_addr_n   = {if_addr[31:2], 2'b00};
               mem_be_n     = 4'b1111;
               mem_wdata_n  = 32'h0;
            end
         end

         IF_BUSY: begin
            if (mem_ack) begin
               state_n    = DONE;
               mem_req_n  = 1'b0;
               if_rdata_n = mem_rdata;
               if_valid_n = 1'b1;
            end
         end

         DM_BUSY: begin
            if (mem_ack) begin
               state_n    = DONE;
               mem_req_n  = 1'b0;
               // Loads return the addressed lane at bit 0; no sign extension.
               dm_rdata_n = ctx.we ? 32'h0 : (mem_rdata >> {ctx.off, 3'b000});
               dm_valid_n = 1'b1;
            end
         end

         DONE: begin
            // Valid pulses were set on entry; this cycle lets requesters drop req.
            state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b0;
         ctx        <= '0;
         if_rdata   <= 32'h0;
         if_valid   <= 1'b0;
         dm_rdata   <= 32'h0;
         dm_valid   <= 1'b0;
         dm_err     <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'h0;
         mem_wdata  <= 32'h0;
         mem_be     <= 4'h0;
      end else begin
         state      <= state_n;
         last_grant <= last_grant_n;
         ctx        <= ctx_n;
         if_rdata   <= if_rdata_n;
         if_valid   <= if_valid_n;
         dm_rdata   <= dm_rdata_n;
         dm_valid   <= dm_valid_n;
         dm_err     <= dm_err_n;
         mem_req    <= mem_req_n;
         mem_we     <= mem_we_n;
         mem_addr   <= mem_addr_n;
         mem_wdata  <= mem_wdata_n;
         mem_be     <= mem_be_n;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, randomized
// transactions against a byte-level reference model, and hand sequences for
// round-robin ties and reset during a transaction.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [1:0]  dm_size = '0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        dm_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_err(dm_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   bit model_last_dm = 1'b0;   // reference: data was served last

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference for a data request, built byte by byte from the access size.
   task automatic model_dm(input bit we, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] mrd,
                           output logic [31:0] e_addr, output logic [3:0] e_be,
                           output logic [31:0] e_wdata, output logic [31:0] e_rdata,
                           output bit e_err);
      int nb, off;
      nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off     = int'(addr[1:0]);
      e_err   = (size == 2'd3) || ((off % nb) != 0);
      e_addr  = addr & 32'hFFFF_FFFC;
      e_be    = '0;
      e_wdata = '0;
      if (!e_err)
         for (int k = 0; k < nb; k++) e_be[off + k] = 1'b1;
      for (int b = 0; b < 4; b++) e_wdata[8*b +: 8] = wdata[8*(b % nb) +: 8];
      e_rdata = (e_err || we) ? 32'h0 : (mrd >> (8 * off));
   endtask

   task automatic do_reset();
      rst = 1'b1; if_req = 0; dm_req = 0; mem_ack = 0;
      repeat (2) @(negedge clk);
      chk("rst_mem_req",  32'(mem_req), 0);
      chk("rst_mem_we",   32'(mem_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_be",   32'(mem_be), 0);
      chk("rst_valids",   32'({if_valid, dm_valid, dm_err}), 0);
      chk("rst_rdata",    if_rdata | dm_rdata | mem_wdata, 0);
      rst = 1'b0;
      model_last_dm = 1'b0;
      @(negedge clk);
   endtask

   // Serves the requested set (one or both requesters) to completion. Payload
   // signals are set by the caller; expectations come in as arguments.
   task automatic serve(input bit want_if, input bit want_dm, input int waits,
                        input logic [31:0] if_mrd, input logic [31:0] if_e_addr,
                        input logic [31:0] if_e_rdata,
                        input logic [31:0] dm_mrd, input logic [31:0] dm_e_addr,
                        input logic [3:0] dm_e_be, input logic [31:0] dm_e_wdata,
                        input logic [31:0] dm_e_rdata, input bit dm_e_err);
      bit pend_if, pend_dm, pick_dm, first;
      int t;
      logic [31:0] e_addr;
      pend_if = want_if; pend_dm = want_dm; first = 1'b1;
      @(negedge clk);
      if_req = pend_if; dm_req = pend_dm;
      while (pend_if || pend_dm) begin
         pick_dm = pend_dm && (!pend_if || !model_last_dm);
         model_last_dm = pick_dm;
         e_addr = pick_dm ? dm_e_addr : if_e_addr;
         t = 0;
         do begin @(negedge clk); t++; end
         while (!(mem_req || if_valid || dm_valid) && t < 20);
         if (!(mem_req || if_valid || dm_valid)) begin
            chk("serve_timeout", 32'(t), 0);
            if_req = 0; dm_req = 0;
            break;
         end
         if (first) chk("grant_latency", 32'(t), 1);
         first = 1'b0;
         if (pick_dm && dm_e_err) begin
            chk("err_dm_valid", 32'(dm_valid), 1);
            chk("err_flag",     32'(dm_err), 1);
            chk("err_rdata",    dm_rdata, 0);
            chk("err_mem_req",  32'(mem_req), 0);
            chk("err_if_valid", 32'(if_valid), 0);
         end else begin
            chk("mem_req",  32'(mem_req), 1);
            chk("mem_we",   32'(mem_we), pick_dm ? 32'(dm_we) : 32'h0);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_be",   32'(mem_be), pick_dm ? 32'(dm_e_be) : 32'hF);
            if (pick_dm && dm_we) chk("mem_wdata", mem_wdata, dm_e_wdata);
            for (int w = 0; w < waits; w++) begin
               @(negedge clk);
               chk("hold_req",  32'(mem_req), 1);
               chk("hold_addr", mem_addr, e_addr);
            end
            mem_rdata = pick_dm ? dm_mrd : if_mrd;
            mem_ack   = 1'b1;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            chk("done_mem_req", 32'(mem_req), 0);
            if (pick_dm) begin
               chk("dm_valid",     32'(dm_valid), 1);
               chk("dm_other",     32'(if_valid), 0);
               chk("dm_rdata",     dm_rdata, dm_e_rdata);
               chk("dm_err_clear", 32'(dm_err), 0);
            end else begin
               chk("if_valid", 32'(if_valid), 1);
               chk("if_other", 32'(dm_valid), 0);
               chk("if_rdata", if_rdata, if_e_rdata);
            end
         end
         if (pick_dm) begin dm_req = 0; pend_dm = 0; end
         else         begin if_req = 0; pend_if = 0; end
      end
      @(negedge clk);
      chk("single_pulse", 32'({if_valid, dm_valid}), 0);
   endtask

   typedef struct {
      bit          is_dm;
      bit          we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrd;
      int          waits;
      logic [31:0] e_addr;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_rdata;
      bit          e_err;
   } vec_t;

   vec_t tbl[11];

   initial begin
      int n, b2b;
      bit prev;
      bit order[4];
      bit exp_order[4];
      logic [31:0] ea, ew, er;
      logic [3:0]  eb;
      bit ee;
      bit wi, wd;

      //          dm we sz     addr          wdata         mrd         w  e_addr        be       e_wdata       e_rdata       err
      tbl[0]  = '{0, 0, 2'd2, 32'h0000_0106, 32'h0,        32'h0000_0013, 0, 32'h104, 4'b1111, 32'h0,        32'h0000_0013, 0};
      tbl[1]  = '{1, 1, 2'd0, 32'h0000_0203, 32'h0000_00AB, 32'h0,        0, 32'h200, 4'b1000, 32'hABAB_ABAB, 32'h0,        0};
      tbl[2]  = '{1, 0, 2'd1, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 3, 32'h100, 4'b1100, 32'h0,        32'h0000_8001, 0};
      tbl[3]  = '{1, 0, 2'd2, 32'h0000_0101, 32'h0,        32'h0,        0, 32'h100, 4'b0000, 32'h0,        32'h0,        1};
      tbl[4]  = '{1, 1, 2'd1, 32'h0000_0106, 32'h0000_1234, 32'h0,        0, 32'h104, 4'b1100, 32'h1234_1234, 32'h0,        0};
      tbl[5]  = '{1, 0, 2'd0, 32'h0000_0301, 32'h0,        32'hAABB_CCDD, 2, 32'h300, 4'b0010, 32'h0,        32'h00AA_BBCC, 0};
      tbl[6]  = '{1, 1, 2'd2, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0,        1, 32'h400, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0};
      tbl[7]  = '{1, 0, 2'd3, 32'h0000_0500, 32'h0,        32'h0,        0, 32'h500, 4'b0000, 32'h0,        32'h0,        1};
      tbl[8]  = '{1, 0, 2'd1, 32'h0000_0103, 32'h0,        32'h0,        0, 32'h100, 4'b0000, 32'h0,        32'h0,        1};
      tbl[9]  = '{1, 0, 2'd2, 32'h0000_010C, 32'h0,        32'hCAFE_F00D, 0, 32'h10C, 4'b1111, 32'h0,        32'hCAFE_F00D, 0};
      tbl[10] = '{1, 0, 2'd0, 32'h0000_0000, 32'h0,        32'h1234_5678, 0, 32'h000, 4'b0001, 32'h0,        32'h1234_5678, 0};

      do_reset();

      // Both requesters held high from reset: data, fetch, data, fetch.
      exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
      if_addr = 32'h40; dm_we = 0; dm_size = 2'd2; dm_addr = 32'h80; mem_rdata = 32'h55;
      if_req = 1; dm_req = 1;
      n = 0; b2b = 0; prev = 0;
      for (int c = 0; c < 100 && n < 4; c++) begin
         @(negedge clk);
         if (if_valid || dm_valid) begin
            if (prev) b2b++;
            if (n < 4) order[n] = dm_valid;
            n++;
         end
         prev    = if_valid || dm_valid;
         mem_ack = mem_req;
      end
      if_req = 0; dm_req = 0; mem_ack = 0;
      chk("rr_grant_count", 32'(n), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("rr_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));
      chk("rr_back_to_back", 32'(b2b), 0);
      model_last_dm = 1'b0;
      repeat (2) @(negedge clk);

      // Directed vector table, one requester at a time.
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].is_dm) begin
            dm_we = tbl[i].we; dm_size = tbl[i].size; dm_addr = tbl[i].addr; dm_wdata = tbl[i].wdata;
         end else begin
            if_addr = tbl[i].addr;
         end
         serve(!tbl[i].is_dm, tbl[i].is_dm, tbl[i].waits,
               tbl[i].mrd, tbl[i].e_addr, tbl[i].e_rdata,
               tbl[i].mrd, tbl[i].e_addr, tbl[i].e_be, tbl[i].e_wdata, tbl[i].e_rdata, tbl[i].e_err);
      end

      // Randomized single and contending requests against the model.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] imrd, dmrd;
         wi = 1'($urandom_range(0, 1));
         wd = 1'($urandom_range(0, 1));
         if (!wi && !wd) wd = 1'b1;
         if_addr  = $urandom;
         dm_we    = 1'($urandom_range(0, 1));
         dm_size  = 2'($urandom_range(0, 3));
         dm_addr  = $urandom;
         dm_wdata = $urandom;
         imrd     = $urandom;
         dmrd     = $urandom;
         model_dm(dm_we, dm_size, dm_addr, dm_wdata, dmrd, ea, eb, ew, er, ee);
         serve(wi, wd, $urandom_range(0, 3), imrd, if_addr & 32'hFFFF_FFFC, imrd,
               dmrd, ea, eb, ew, er, ee);
      end

      // Reset while a load waits on memory; a late ack must be ignored.
      do_reset();
      dm_we = 0; dm_size = 2'd2; dm_addr = 32'h0000_0080;
      dm_req = 1;
      @(negedge clk);
      chk("busy_mem_req", 32'(mem_req), 1);
      #1 rst = 1'b1;
      #1 chk("rst_async_mem_req", 32'(mem_req), 0);
      dm_req = 0; mem_ack = 1; mem_rdata = 32'h1111_2222;
      @(negedge clk);
      rst = 1'b0;
      model_last_dm = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("late_ack_no_valid", 32'({dm_valid, if_valid}), 0);
         chk("late_ack_mem_req",  32'(mem_req), 0);
      end
      mem_ack = 0;

      // First tie after that reset goes to data.
      if_addr = 32'h0000_0020; dm_we = 0; dm_size = 2'd2; dm_addr = 32'h0000_0030;
      serve(1, 1, 0, 32'h0BAD_F00D, 32'h20, 32'h0BAD_F00D,
            32'h600D_CAFE, 32'h30, 4'b1111, 32'h0, 32'h600D_CAFE, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
